// File: rtl/ssp_frame_codec.sv
// SSP serialiser/deserialiser: derives ssp_clk/ssp_frame from ck_1356meg, shifts TX words out, assembles RX words.
// Optional build macro SSP_LOOPBACK_EN adds a "loopback" input that routes ssp_din back into the RX sampler.
module ssp_frame_codec #(
  parameter int FRAME_BITS = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  ck_1356meg,
  input  logic                  reset,
  input  logic                  lsb_first,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  ssp_clk,
  output logic                  ssp_frame,
  output logic                  ssp_din,
  input  logic                  ssp_dout
`ifdef SSP_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] RISE_PRE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic [DW-1:0]         div_r, div_nxt_s;
  logic [BW-1:0]         bit_r, bit_nxt_s;
  logic                  primed_r;
  logic                  ssp_clk_r, ssp_frame_r, ssp_din_r, din_nxt_s;
  logic                  tx_ready_r, ready_nxt_s, tx_underrun_r;
  logic [FRAME_BITS-1:0] hold_r, hold_nxt_s, sr_r, sr_nxt_s;
  logic                  lsb_r, lsb_nxt_s;
  logic [FRAME_BITS-1:0] rx_sr_r, rx_word_s, rx_data_r;
  logic                  rx_valid_r;
  logic                  rise_s, fall_s, boundary_s, write_s, rx_sample_s;

  // Position of serial bit index idx within the word for the given order.
  function automatic logic [BW-1:0] bit_pos(input logic lsb, input logic [BW-1:0] idx);
    bit_pos = lsb ? idx : (BIT_LAST - idx);
  endfunction

`ifdef SSP_LOOPBACK_EN
  assign rx_sample_s = loopback ? ssp_din_r : ssp_dout;
`else
  assign rx_sample_s = ssp_dout;
`endif

  // Timing events, holding-register handshake and next serial/RX state.
  always_comb begin
    rise_s     = (div_r == RISE_PRE);
    fall_s     = (div_r == DIV_LAST);
    boundary_s = fall_s && (bit_r == BIT_LAST);
    write_s    = tx_valid && tx_ready_r;
    div_nxt_s  = fall_s ? '0 : (div_r + DW'(1));
    if (boundary_s) begin
      bit_nxt_s = '0;
    end else if (fall_s) begin
      bit_nxt_s = bit_r + BW'(1);
    end else begin
      bit_nxt_s = bit_r;
    end
    // A write landing on the boundary is not bypassed into the shift register.
    if (boundary_s) begin
      sr_nxt_s    = tx_ready_r ? '0 : hold_r;
      lsb_nxt_s   = lsb_first;
      ready_nxt_s = !write_s;
    end else begin
      sr_nxt_s    = sr_r;
      lsb_nxt_s   = lsb_r;
      ready_nxt_s = tx_ready_r && !write_s;
    end
    hold_nxt_s = write_s ? tx_data : hold_r;
    din_nxt_s  = fall_s ? sr_nxt_s[bit_pos(lsb_nxt_s, bit_nxt_s)] : ssp_din_r;
    rx_word_s  = rx_sr_r;
    rx_word_s[bit_pos(lsb_r, bit_r)] = rx_sample_s;
  end

  // State and registered outputs.
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      div_r         <= '0;
      bit_r         <= BIT_LAST;
      primed_r      <= 1'b0;
      ssp_clk_r     <= 1'b0;
      ssp_frame_r   <= 1'b0;
      ssp_din_r     <= 1'b0;
      tx_ready_r    <= 1'b1;
      tx_underrun_r <= 1'b0;
      hold_r        <= '0;
      sr_r          <= '0;
      lsb_r         <= 1'b0;
      rx_sr_r       <= '0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
    end else begin
      div_r         <= div_nxt_s;
      bit_r         <= bit_nxt_s;
      primed_r      <= primed_r || boundary_s;
      ssp_clk_r     <= (div_nxt_s >= DIV_HALF);
      ssp_frame_r   <= (bit_nxt_s == '0);
      ssp_din_r     <= din_nxt_s;
      tx_ready_r    <= ready_nxt_s;
      tx_underrun_r <= boundary_s && tx_ready_r;
      hold_r        <= hold_nxt_s;
      sr_r          <= sr_nxt_s;
      lsb_r         <= lsb_nxt_s;
      rx_sr_r       <= rise_s ? rx_word_s : rx_sr_r;
      rx_valid_r    <= rise_s && (bit_r == BIT_LAST) && primed_r;
      rx_data_r     <= (rise_s && (bit_r == BIT_LAST) && primed_r) ? rx_word_s : rx_data_r;
    end
  end

  assign tx_ready    = tx_ready_r;
  assign tx_underrun = tx_underrun_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign ssp_clk     = ssp_clk_r;
  assign ssp_frame   = ssp_frame_r;
  assign ssp_din     = ssp_din_r;

endmodule

// File: tb/tb_ssp_frame_codec.sv
// Randomised self-checking bench for ssp_frame_codec against a time-indexed behavioural model.
module tb_ssp_frame_codec;
  localparam int FB   = 8;
  localparam int CD   = 4;
  localparam int HALF = CD / 2;

  logic          clk = 1'b0;
  logic          reset, lsb_first, tx_valid, ssp_dout;
  logic [FB-1:0] tx_data;
  logic          tx_ready, tx_underrun, rx_valid, ssp_clk, ssp_frame, ssp_din;
  logic [FB-1:0] rx_data;
`ifdef SSP_LOOPBACK_EN
  logic          loopback;
`endif

  always #5 clk = ~clk;

  ssp_frame_codec #(.FRAME_BITS(FB), .CLK_DIV(CD)) dut (
    .ck_1356meg(clk), .reset(reset), .lsb_first(lsb_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
    .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
    .ssp_dout(ssp_dout)
`ifdef SSP_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: n counts clock edges since the last edge that saw reset high.
  int            n;
  logic          m_full, m_lsb, m_primed;
  logic [FB-1:0] m_hold, m_word, m_rxd;
  logic          m_clk, m_frame, m_din, m_under, m_rxv;
  bit            m_bnd, m_fall, m_acc;
  bit            rxq[$];

  // Stimulus state
  bit            wr_pend, pat_mode, rand_mode;
  logic [FB-1:0] wr_word, pat, cap, last_frame, last_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bit_index(input int cnt);
    return (FB - 1 + cnt / CD) % FB;
  endfunction

  task automatic model_step();
    logic   lb, smp;
    int     b;
    logic [FB-1:0] w;
`ifdef SSP_LOOPBACK_EN
    lb = loopback;
`else
    lb = 1'b0;
`endif
    m_bnd = 0; m_fall = 0; m_acc = 0;
    if (reset) begin
      n = 0; m_full = 0; m_primed = 0; m_lsb = 0; m_hold = '0; m_word = '0;
      m_clk = 0; m_frame = 0; m_din = 0; m_under = 0; m_rxv = 0; m_rxd = '0;
      rxq.delete();
      return;
    end
    m_acc = tx_valid && !m_full;
    n++;
    b       = bit_index(n);
    m_fall  = (n % CD) == 0;
    m_bnd   = m_fall && (b == 0);
    m_clk   = (n % CD) >= HALF;
    m_frame = (b == 0);
    m_under = m_bnd && !m_full;
    m_rxv   = 0;
    if (m_bnd) begin
      m_primed = 1;
      m_lsb    = lsb_first;
      m_word   = m_full ? m_hold : '0;
      m_full   = m_acc;
      if (m_acc) m_hold = tx_data;
    end else if (m_acc) begin
      m_full = 1;
      m_hold = tx_data;
    end
    if (m_fall) m_din = m_lsb ? m_word[b] : m_word[FB-1-b];
    if ((n % CD) == HALF) begin
      smp = lb ? m_din : ssp_dout;
      if (b == 0) rxq.delete();
      rxq.push_back(smp);
      if (b == FB - 1 && m_primed && rxq.size() == FB) begin
        for (int i = 0; i < FB; i++) begin
          if (m_lsb) w[i] = rxq[i];
          else       w[FB-1-i] = rxq[i];
        end
        m_rxd = w;
        m_rxv = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("tx_ready",    tx_ready,    !m_full);
    check("tx_underrun", tx_underrun, m_under);
    check("rx_valid",    rx_valid,    m_rxv);
    check("rx_data",     rx_data,     m_rxd);
    check("ssp_clk",     ssp_clk,     m_clk);
    check("ssp_frame",   ssp_frame,   m_frame);
    check("ssp_din",     ssp_din,     m_din);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (m_fall) begin
      if (m_bnd) last_frame = cap;
      cap = {cap[FB-2:0], ssp_din};
    end
    if (rx_valid) last_rx = rx_data;
    if (m_acc) wr_pend = 0;
    if (rand_mode && !wr_pend && $urandom_range(0, 3) == 0) begin
      wr_pend = 1;
      wr_word = FB'($urandom);
    end
    tx_valid = wr_pend;
    tx_data  = wr_pend ? wr_word : FB'($urandom);
    ssp_dout = pat_mode ? pat[FB-1-bit_index(n)] : 1'($urandom);
  endtask

  task automatic wait_boundary(input string name);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!m_bnd && k < 200);
    if (!m_bnd) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; lsb_first = 1'b0; tx_valid = 1'b0; tx_data = '0; ssp_dout = 1'b0;
`ifdef SSP_LOOPBACK_EN
    loopback = 1'b0;
`endif
    wr_pend = 0; pat_mode = 0; rand_mode = 0; wr_word = '0; pat = '0;
    cap = '0; last_frame = '0; last_rx = '0; n = 0;
    for (int i = 0; i < 10; i++) cycle();
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_ssp_frame", ssp_frame, 1'b0);
    reset = 1'b0;

    cnt = 0;
    while (ssp_frame !== 1'b1 && cnt < 20) begin
      cycle();
      cnt++;
    end
    check("first_frame_delay", cnt, 32'd4);
    check("first_underrun", tx_underrun, 1'b1);

    wr_word = 8'h0F; wr_pend = 1; lsb_first = 1'b0;
    wait_boundary("b1");
    check("frame0_empty", last_frame, 8'h00);
    pat = 8'b00110110; pat_mode = 1;
    wr_word = 8'h0F; wr_pend = 1;
    for (int i = 0; i < 6; i++) cycle();
    lsb_first = 1'b1;
    wait_boundary("b2");
    check("tx_0F_msb", last_frame, 8'h0F);
    check("rx_msb", last_rx, 8'h36);
    wr_word = 8'hA1; wr_pend = 1;
    for (int i = 0; i < 4; i++) cycle();
    lsb_first = 1'b0;
    wr_word = 8'hB2; wr_pend = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("held_not_ready", tx_ready, 1'b0);
    wait_boundary("b3");
    check("tx_0F_lsb", last_frame, 8'hF0);
    check("rx_lsb", last_rx, 8'h6C);
    wait_boundary("b4");
    check("tx_A1", last_frame, 8'hA1);
    check("no_underrun_b4", tx_underrun, 1'b0);
    wait_boundary("b5");
    check("tx_B2", last_frame, 8'hB2);

    pat_mode = 0; rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) lsb_first = 1'($urandom);
`ifdef SSP_LOOPBACK_EN
      if ($urandom_range(0, 63) == 0) loopback = 1'($urandom);
`endif
      if (i == 1500 + int'($urandom_range(0, 20))) begin
        reset = 1'b1;
        for (int j = 0; j < 3; j++) cycle();
        wr_pend = 0;
        reset = 1'b0;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
